// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and lane helpers for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2
  } dmem_state_t;

  // Request fields latched at accept; the address width here sets the responder's byte-address width.
  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

  // True when the request must be answered with an error (illegal funct3 or misaligned).
  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] lane);
    logic legal_f3;
    logic misaligned;
    case (funct3)
      F3_B, F3_H, F3_W: legal_f3 = 1'b1;
      F3_BU, F3_HU:     legal_f3 = ~we;   // unsigned variants exist only for loads
      default:          legal_f3 = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                 ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    return ~legal_f3 | misaligned;
  endfunction

  // Extract the addressed lane(s) of a little-endian word and extend to 32 bits.
  function automatic logic [DMEM_DATA_W-1:0] load_format(input logic [DMEM_DATA_W-1:0] word,
                                                         input logic [1:0] lane,
                                                         input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [DMEM_DATA_W-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'h000000, b};
      F3_HU:   r = {16'h0000, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with the low bits of the store data.
  function automatic logic [DMEM_DATA_W-1:0] store_merge(input logic [DMEM_DATA_W-1:0] word,
                                                         input logic [DMEM_DATA_W-1:0] wdata,
                                                         input logic [1:0] lane,
                                                         input logic [2:0] funct3);
    logic [DMEM_DATA_W-1:0] m;
    m = word;
    case (funct3)
      F3_B: m[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) m[31:16] = wdata[15:0];
        else         m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_responder_word_ram.sv
// Single-port word RAM: registered read, write-first, array never reset.
module dmem_word_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  // Write the word when enabled; read port returns the freshly written data on a write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata_q     <= wdata;
    end else begin
      rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: byte/half/word loads and stores with error responses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int RAM_AW = DM_ADDRESS - 2;

  dmem_state_t         state_q;
  dmem_req_t           req_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;

  logic                accept;
  logic                in_err;
  logic                in_sw;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign in_err    = req_error(req_we, req_funct3, req_addr[1:0]);
  assign in_sw     = req_we && (req_funct3 == F3_W);

  // RAM port steering: IDLE reads/writes the incoming address, RD/RMW use the captured request.
  // Reset gates every write so an aborted read-modify-write leaves memory untouched.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = req_addr[DM_ADDRESS-1:2];
    ram_wdata = req_wdata;
    case (state_q)
      IDLE: ram_we = accept && !in_err && in_sw && !reset;
      RD:   ram_addr = req_q.addr[DM_ADDRESS-1:2];
      RMW: begin
        ram_addr  = req_q.addr[DM_ADDRESS-1:2];
        ram_wdata = store_merge(ram_rdata, req_q.wdata, req_q.addr[1:0], req_q.funct3);
        ram_we    = req_q.we && !reset;
      end
      default: ram_we = 1'b0;
    endcase
  end

  dmem_word_ram #(
    .AW (RAM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Control FSM with registered response outputs; responses are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata, funct3: req_funct3};
            if (in_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (in_sw) begin
              resp_valid_q <= 1'b1;
            end else if (req_we) begin
              state_q <= RMW;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_format(ram_rdata, req_q.addr[1:0], req_q.funct3);
          state_q      <= IDLE;
        end
        RMW: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request, then observe: ready right after accept, response latency, data, error.
  task automatic do_txn(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat, output logic rdy1);
    int n;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    rdata = '0; err = 1'b0; lat = 0; rdy1 = 1'b0;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h: req_ready=%b, required 1 within 10 cycles", addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) rdy1 = req_ready;
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h: no resp_valid within 6 cycles, required 1", addr);
    end
    $display("txn we=%0b f3=%03b addr=%03h wdata=%08h -> lat=%0d rdata=%08h err=%0b rdy1=%0b",
             we, f3, addr, wdata, lat, rdata, err, rdy1);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_err, req_ready} !== 3'b001 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: valid/err/ready=%b rdata=%h, required 001 rdata=0",
               {resp_valid, resp_err, req_ready}, resp_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; logic r1;
    do_txn(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, rd, er, lat, r1);
    checks++;
    if (lat !== 1 || er !== 1'b0 || rd !== 32'h0 || r1 !== 1'b1) begin
      errors++;
      $display("FAIL sw: lat=%0d err=%b rdata=%h ready=%b, required lat=1 err=0 rdata=0 ready=1", lat, er, rd, r1);
    end
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || r1 !== 1'b0) begin
      errors++;
      $display("FAIL lw: lat=%0d err=%b rdata=%h ready=%b, required lat=2 err=0 rdata=deadbeef ready=0", lat, er, rd, r1);
    end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [8:0]  ad  [4] = '{9'h013, 9'h013, 9'h012, 9'h010};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    logic [31:0] rd; logic er; int lat; logic r1;
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, ad[i], 32'h0, f3[i], rd, er, lat, r1);
      checks++;
      if (rd !== exp[i] || er !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL load_fmt[%0d]: rdata=%h err=%b lat=%0d, required rdata=%h err=0 lat=2", i, rd, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat; logic r1;
    do_txn(1'b1, 9'h011, 32'h00000055, 3'b000, rd, er, lat, r1);
    checks++;
    if (lat !== 2 || r1 !== 1'b0 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sb: lat=%0d ready=%b err=%b rdata=%h, required lat=2 ready=0 err=0 rdata=0", lat, r1, er, rd);
    end
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'hDEAD55EF) begin
      errors++;
      $display("FAIL sb_readback: rdata=%h, required dead55ef", rd);
    end
    do_txn(1'b1, 9'h012, 32'hFFFF1234, 3'b001, rd, er, lat, r1);
    checks++;
    if (lat !== 2 || r1 !== 1'b0 || er !== 1'b0) begin
      errors++;
      $display("FAIL sh: lat=%0d ready=%b err=%b, required lat=2 ready=0 err=0", lat, r1, er);
    end
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'h123455EF) begin
      errors++;
      $display("FAIL sh_readback: rdata=%h, required 123455ef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; logic r1;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 9'h020; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 9'h024; req_wdata = 32'h0BADC0DE;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: valid=%b ready=%b err=%b, required 1 1 0", resp_valid, req_ready, resp_err);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b err=%b, required 1 0", resp_valid, resp_err);
    end
    $display("txn b2b sw 020=cafef00d, 024=0badc0de");
    do_txn(1'b0, 9'h020, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_read020: rdata=%h, required cafef00d", rd);
    end
    do_txn(1'b0, 9'h024, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL b2b_read024: rdata=%h, required 0badc0de", rd);
    end
    do_txn(1'b0, 9'h020, 32'h0, 3'b001, rd, er, lat, r1);
    checks++;
    if (rd !== 32'hFFFFF00D) begin
      errors++;
      $display("FAIL lh_low_half: rdata=%h, required fffff00d", rd);
    end
  endtask

  task automatic test_errors();
    logic        we  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0]  ad  [5] = '{9'h011, 9'h013, 9'h010, 9'h010, 9'h012};
    logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] rd; logic er; int lat; logic r1;
    for (int i = 0; i < 5; i++) begin
      do_txn(we[i], ad[i], 32'hFFFFFFFF, f3[i], rd, er, lat, r1);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || r1 !== 1'b1) begin
        errors++;
        $display("FAIL err[%0d]: err=%b rdata=%h lat=%0d ready=%b, required err=1 rdata=0 lat=1 ready=1", i, er, rd, lat, r1);
      end
    end
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'h123455EF) begin
      errors++;
      $display("FAIL err_no_write: rdata=%h, required 123455ef", rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; logic r1;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 9'h010; req_wdata = 32'h000000AA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: ready=%b, required 0", req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: valid=%b ready=%b, required 0 1", resp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resp: valid=%b, required 0", resp_valid);
    end
    $display("txn aborted sb 010=aa");
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, rd, er, lat, r1);
    checks++;
    if (rd !== 32'h123455EF) begin
      errors++;
      $display("FAIL abort_ram: rdata=%h, required 123455ef", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_load_format();
    test_subword_store();
    test_back_to_back();
    test_errors();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
